shift_sched: RTL and testbench

SHIFT_SCHED -- requirements
Module: shift_sched

---
 rtl/shift_sched.sv | 219 +++++++++++++++++++++
 tb/tb_shift_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sched.sv
// shift_sched: round-robin scheduler lending one shift buffer to NUM_REQ requesters.
// Optional stall counter is built only when SHIFT_SCHED_STALL_CNT_EN is defined.
module shift_sched #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 Rst,
    input  logic [NUM_REQ-1:0]                   req_vld,
    output logic [NUM_REQ-1:0]                   req_rdy,
    input  logic [NUM_REQ-1:0]                   req_incr,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_bytestep,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_wrbackstep,
    input  logic [NUM_REQ-1:0][CNT_WIDTH-1:0]    req_nin,
    input  logic [NUM_REQ-1:0][CNT_WIDTH-1:0]    req_nout,
    output logic [NUM_REQ-1:0]                   req_done,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic                                 shift_ByteWrIncr,
    output logic [ADDR_WIDTH-1:0]                shift_ByteWrStep,
    output logic [ADDR_WIDTH-1:0]                shift_WrBackStep,
    output logic                                 shift_Rst,
    output logic                                 shift_din_en,
    output logic                                 shift_din_last,
    input  logic                                 shift_din_vld,
    input  logic                                 shift_din_rdy,
    input  logic                                 shift_dout_vld,
    input  logic                                 shift_dout_rdy,
    output logic                                 busy,
    output logic [CNT_WIDTH-1:0]                 cnt_stall
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        CLR   = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [IDX_W-1:0]       ptr_r;
    logic [IDX_W-1:0]       gnt_idx_r;
    logic [IDX_W-1:0]       hi_idx_s;
    logic [IDX_W-1:0]       lo_idx_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic                   hi_found_s;
    logic                   lo_found_s;
    logic                   accept_s;
    logic [CNT_WIDTH-1:0]   nin_sel_s;
    logic [CNT_WIDTH-1:0]   nout_sel_s;
    logic [CNT_WIDTH-1:0]   nin_r;
    logic [CNT_WIDTH-1:0]   nout_r;
    logic [CNT_WIDTH-1:0]   in_cnt_r;
    logic [CNT_WIDTH-1:0]   out_cnt_r;
    logic                   din_hs_s;
    logic                   dout_hs_s;
    logic                   in_last_s;
    logic                   out_last_s;

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = {NUM_REQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign din_hs_s   = shift_din_vld & shift_din_rdy;
    assign dout_hs_s  = shift_dout_vld & shift_dout_rdy;
    assign in_last_s  = (in_cnt_r == (nin_r - CNT_WIDTH'(1'b1)));
    assign out_last_s = (out_cnt_r == (nout_r - CNT_WIDTH'(1'b1)));
    assign nin_sel_s  = req_nin[win_idx_s];
    assign nout_sel_s = req_nout[win_idx_s];

    // Round-robin pick: lowest requester above the pointer, else lowest overall.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = {IDX_W{1'b0}};
        lo_idx_s   = {IDX_W{1'b0}};
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            hi_idx_s   = (req_vld[j] && (IDX_W'(j) > ptr_r)) ? IDX_W'(j) : hi_idx_s;
            hi_found_s = hi_found_s | (req_vld[j] && (IDX_W'(j) > ptr_r));
            lo_idx_s   = req_vld[j] ? IDX_W'(j) : lo_idx_s;
            lo_found_s = lo_found_s | req_vld[j];
        end
        win_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Next-state decode; an empty input or output phase skips straight to CLR.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (lo_found_s) begin
                    accept_s = 1'b1;
                    if ((nin_sel_s == {CNT_WIDTH{1'b0}}) || (nout_sel_s == {CNT_WIDTH{1'b0}})) begin
                        state_nxt_s = CLR;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                if (din_hs_s && in_last_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            DRAIN: begin
                if (dout_hs_s && out_last_s) begin
                    state_nxt_s = CLR;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            CLR: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake and buffer-control outputs; reset masks everything but the buffer clear.
    always_comb begin
        req_rdy        = {NUM_REQ{1'b0}};
        req_done       = {NUM_REQ{1'b0}};
        shift_din_en   = 1'b0;
        shift_din_last = 1'b0;
        busy           = 1'b0;
        shift_Rst      = Rst | (state_r == CLR);
        if (!Rst) begin
            req_rdy        = accept_s ? to_onehot(win_idx_s) : {NUM_REQ{1'b0}};
            req_done       = (state_r == CLR) ? gnt : {NUM_REQ{1'b0}};
            shift_din_en   = (state_r == FILL);
            shift_din_last = (state_r == FILL) && in_last_s;
            busy           = (state_r != IDLE);
        end else begin
            req_rdy        = {NUM_REQ{1'b0}};
        end
    end

    // State register, grant ownership and round-robin pointer.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_r   <= IDLE;
            ptr_r     <= IDX_W'(NUM_REQ - 1);
            gnt_idx_r <= {IDX_W{1'b0}};
            gnt       <= {NUM_REQ{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                gnt_idx_r <= win_idx_s;
                gnt       <= to_onehot(win_idx_s);
            end else if (state_r == CLR) begin
                ptr_r <= gnt_idx_r;
                gnt   <= {NUM_REQ{1'b0}};
            end
        end
    end

    // Latched transaction config and beat counters.
    always_ff @(posedge clk) begin
        if (Rst) begin
            shift_ByteWrIncr <= 1'b0;
            shift_ByteWrStep <= {ADDR_WIDTH{1'b0}};
            shift_WrBackStep <= {ADDR_WIDTH{1'b0}};
            nin_r            <= {CNT_WIDTH{1'b0}};
            nout_r           <= {CNT_WIDTH{1'b0}};
            in_cnt_r         <= {CNT_WIDTH{1'b0}};
            out_cnt_r        <= {CNT_WIDTH{1'b0}};
        end else if (accept_s) begin
            shift_ByteWrIncr <= req_incr[win_idx_s];
            shift_ByteWrStep <= req_bytestep[win_idx_s];
            shift_WrBackStep <= req_wrbackstep[win_idx_s];
            nin_r            <= nin_sel_s;
            nout_r           <= nout_sel_s;
            in_cnt_r         <= {CNT_WIDTH{1'b0}};
            out_cnt_r        <= {CNT_WIDTH{1'b0}};
        end else begin
            if ((state_r == FILL) && din_hs_s) begin
                in_cnt_r <= in_cnt_r + CNT_WIDTH'(1'b1);
            end
            if ((state_r == DRAIN) && dout_hs_s) begin
                out_cnt_r <= out_cnt_r + CNT_WIDTH'(1'b1);
            end
        end
    end

`ifdef SHIFT_SCHED_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_r;
    logic                 stall_ev_s;

    assign stall_ev_s = ((state_r == FILL)  && shift_din_vld  && !shift_din_rdy) ||
                        ((state_r == DRAIN) && shift_dout_vld && !shift_dout_rdy);

    // Saturating count of back-pressured cycles for the current transaction.
    always_ff @(posedge clk) begin
        if (Rst || accept_s) begin
            stall_r <= {CNT_WIDTH{1'b0}};
        end else if (stall_ev_s && (stall_r != {CNT_WIDTH{1'b1}})) begin
            stall_r <= stall_r + CNT_WIDTH'(1'b1);
        end
    end

    assign cnt_stall = stall_r;
`else
    assign cnt_stall = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_shift_sched.sv
// Directed self-checking bench for shift_sched (default parameters).
module tb_shift_sched;

    localparam int NR = 2;
    localparam int AW = 8;
    localparam int CW = 16;
`ifdef SHIFT_SCHED_STALL_CNT_EN
    localparam int STALL_EXP = 5;
`else
    localparam int STALL_EXP = 0;
`endif

    logic                   clk = 1'b0;
    logic                   Rst;
    logic [NR-1:0]          req_vld;
    logic [NR-1:0]          req_rdy;
    logic [NR-1:0]          req_incr;
    logic [NR-1:0][AW-1:0]  req_bytestep;
    logic [NR-1:0][AW-1:0]  req_wrbackstep;
    logic [NR-1:0][CW-1:0]  req_nin;
    logic [NR-1:0][CW-1:0]  req_nout;
    logic [NR-1:0]          req_done;
    logic [NR-1:0]          gnt;
    logic                   shift_ByteWrIncr;
    logic [AW-1:0]          shift_ByteWrStep;
    logic [AW-1:0]          shift_WrBackStep;
    logic                   shift_Rst;
    logic                   shift_din_en;
    logic                   shift_din_last;
    logic                   shift_din_vld;
    logic                   shift_din_rdy;
    logic                   shift_dout_vld;
    logic                   shift_dout_rdy;
    logic                   busy;
    logic [CW-1:0]          cnt_stall;

    int n_total = 0;
    int n_bad   = 0;
    int busy_cnt;
    int n_grants;
    logic prev_done;

    always #5 clk = ~clk;

    shift_sched #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .Rst(Rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_incr(req_incr),
        .req_bytestep(req_bytestep), .req_wrbackstep(req_wrbackstep),
        .req_nin(req_nin), .req_nout(req_nout), .req_done(req_done), .gnt(gnt),
        .shift_ByteWrIncr(shift_ByteWrIncr), .shift_ByteWrStep(shift_ByteWrStep),
        .shift_WrBackStep(shift_WrBackStep), .shift_Rst(shift_Rst),
        .shift_din_en(shift_din_en), .shift_din_last(shift_din_last),
        .shift_din_vld(shift_din_vld), .shift_din_rdy(shift_din_rdy),
        .shift_dout_vld(shift_dout_vld), .shift_dout_rdy(shift_dout_rdy),
        .busy(busy), .cnt_stall(cnt_stall)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1; req_vld = 2'b00; req_incr = 2'b00;
        req_bytestep = '0; req_wrbackstep = '0; req_nin = '0; req_nout = '0;
        shift_din_vld = 1'b0; shift_din_rdy = 1'b0;
        shift_dout_vld = 1'b0; shift_dout_rdy = 1'b0;

        // reset state
        tick(); #1;
        check_val("rst_shift_rst", 32'(shift_Rst), 32'd1);
        tick(); Rst = 1'b0; #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_rdy", 32'(req_rdy), 32'd0);
        check_val("rst_done", 32'(req_done), 32'd0);
        check_val("rst_shift_rst_low", 32'(shift_Rst), 32'd0);
        check_val("rst_cfg_step", 32'(shift_ByteWrStep), 32'd0);
        check_val("rst_din_en", 32'(shift_din_en), 32'd0);
        check_val("rst_stall", 32'(cnt_stall), 32'd0);

        // single transaction, nin=4 nout=2, one idle cycle at start of DRAIN
        tick();
        req_vld = 2'b01; req_nin[0] = 16'd4; req_nout[0] = 16'd2;
        req_incr[0] = 1'b0; req_bytestep[0] = 8'd5; req_wrbackstep[0] = 8'd9;
        shift_din_vld = 1'b1; shift_din_rdy = 1'b1; shift_dout_rdy = 1'b1;
        #1;
        check_val("t1_rdy", 32'(req_rdy), 32'd1);
        check_val("t1_idle_din_en", 32'(shift_din_en), 32'd0);
        busy_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            tick(); req_vld = 2'b00; #1;
            check_val("t1_din_en", 32'(shift_din_en), 32'd1);
            check_val("t1_last", 32'(shift_din_last), (b == 3) ? 32'd1 : 32'd0);
            check_val("t1_gnt", 32'(gnt), 32'd1);
            if (busy) busy_cnt++;
        end
        check_val("t1_cfg_step", 32'(shift_ByteWrStep), 32'd5);
        check_val("t1_cfg_wb", 32'(shift_WrBackStep), 32'd9);
        tick(); shift_din_vld = 1'b0; #1;
        check_val("t1_drain_din_en", 32'(shift_din_en), 32'd0);
        if (busy) busy_cnt++;
        tick(); shift_dout_vld = 1'b1; #1;
        if (busy) busy_cnt++;
        tick(); #1;
        check_val("t1_drain_no_done", 32'(req_done), 32'd0);
        if (busy) busy_cnt++;
        tick(); shift_dout_vld = 1'b0; #1;
        check_val("t1_clr_shift_rst", 32'(shift_Rst), 32'd1);
        check_val("t1_clr_done", 32'(req_done), 32'd1);
        check_val("t1_clr_gnt", 32'(gnt), 32'd1);
        if (busy) busy_cnt++;
        tick(); #1;
        check_val("t1_idle_busy", 32'(busy), 32'd0);
        check_val("t1_idle_gnt", 32'(gnt), 32'd0);
        check_val("t1_busy_cycles", 32'(busy_cnt), 32'd8);

        // config latch on req1, inputs change after acceptance
        tick();
        req_vld = 2'b10; req_incr[1] = 1'b1; req_bytestep[1] = 8'd3; req_wrbackstep[1] = 8'd7;
        req_nin[1] = 16'd1; req_nout[1] = 16'd1;
        shift_din_vld = 1'b1; shift_din_rdy = 1'b1; shift_dout_vld = 1'b1; shift_dout_rdy = 1'b1;
        #1;
        check_val("t2_rdy", 32'(req_rdy), 32'd2);
        check_val("t2_cfg_before", 32'(shift_ByteWrStep), 32'd5);
        tick(); req_vld = 2'b00; req_incr[1] = 1'b0; req_bytestep[1] = 8'h11; req_wrbackstep[1] = 8'h22; #1;
        check_val("t2_incr", 32'(shift_ByteWrIncr), 32'd1);
        check_val("t2_step", 32'(shift_ByteWrStep), 32'd3);
        check_val("t2_wb", 32'(shift_WrBackStep), 32'd7);
        check_val("t2_gnt", 32'(gnt), 32'd2);
        tick(); #1;
        check_val("t2_drain_step", 32'(shift_ByteWrStep), 32'd3);
        tick(); #1;
        check_val("t2_done", 32'(req_done), 32'd2);
        check_val("t2_clr_wb", 32'(shift_WrBackStep), 32'd7);
        tick(); #1;
        check_val("t2_idle_incr", 32'(shift_ByteWrIncr), 32'd1);
        check_val("t2_idle_gnt", 32'(gnt), 32'd0);

        // nin=0 goes straight to CLR
        tick(); req_vld = 2'b10; req_nin[1] = 16'd0; req_nout[1] = 16'd3; #1;
        check_val("t3_rdy", 32'(req_rdy), 32'd2);
        check_val("t3_idle_last", 32'(shift_din_last), 32'd0);
        tick(); req_vld = 2'b00; #1;
        check_val("t3_din_en", 32'(shift_din_en), 32'd0);
        check_val("t3_last", 32'(shift_din_last), 32'd0);
        check_val("t3_shift_rst", 32'(shift_Rst), 32'd1);
        check_val("t3_done", 32'(req_done), 32'd2);
        tick(); #1;
        check_val("t3_idle", 32'(busy), 32'd0);

        // both requesters continuously: grants alternate 0,1,0,1
        tick();
        req_nin[0] = 16'd1; req_nout[0] = 16'd1; req_nin[1] = 16'd1; req_nout[1] = 16'd1;
        req_vld = 2'b11;
        #1;
        n_grants = 0;
        prev_done = 1'b0;
        for (int c = 0; c < 40 && n_grants < 4; c++) begin
            if (c > 0) tick();
            check_val("t4_gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (req_rdy != 2'b00) begin
                check_val("t4_order", 32'(req_rdy), (n_grants % 2 == 0) ? 32'd1 : 32'd2);
                check_val("t4_accept_idle", 32'(busy), 32'd0);
                if (n_grants > 0) check_val("t4_after_clr", 32'(prev_done), 32'd1);
                n_grants++;
            end
            prev_done = (req_done != 2'b00);
        end
        check_val("t4_grants", 32'(n_grants), 32'd4);
        req_vld = 2'b00;
        for (int k = 0; k < 4; k++) tick();
        #1;
        check_val("t4_end_idle", 32'(busy), 32'd0);

        // stall counting: nin=3, din_rdy low 5 cycles mid-FILL
        tick(); req_vld = 2'b01; req_nin[0] = 16'd3; req_nout[0] = 16'd1; #1;
        check_val("t5_rdy", 32'(req_rdy), 32'd1);
        tick(); req_vld = 2'b00; #1;
        check_val("t5_last_b0", 32'(shift_din_last), 32'd0);
        for (int s = 0; s < 5; s++) begin
            tick(); shift_din_rdy = 1'b0; #1;
            check_val("t5_stall_last", 32'(shift_din_last), 32'd0);
        end
        tick(); shift_din_rdy = 1'b1; #1;
        check_val("t5_last_b1", 32'(shift_din_last), 32'd0);
        tick(); #1;
        check_val("t5_last_b2", 32'(shift_din_last), 32'd1);
        tick(); #1;
        check_val("t5_drain_din_en", 32'(shift_din_en), 32'd0);
        tick(); #1;
        check_val("t5_done", 32'(req_done), 32'd1);
        check_val("t5_stall_cnt", 32'(cnt_stall), 32'(STALL_EXP));
        tick(); #1;

        // reset during DRAIN with out_cnt=1
        tick(); req_vld = 2'b10; req_nin[1] = 16'd1; req_nout[1] = 16'd3; #1;
        check_val("t6_rdy", 32'(req_rdy), 32'd2);
        tick(); req_vld = 2'b00; #1;
        tick(); #1;
        tick(); Rst = 1'b1; shift_dout_vld = 1'b0; #1;
        check_val("t6_shift_rst", 32'(shift_Rst), 32'd1);
        check_val("t6_no_done", 32'(req_done), 32'd0);
        tick(); Rst = 1'b0; #1;
        check_val("t6_busy", 32'(busy), 32'd0);
        check_val("t6_gnt", 32'(gnt), 32'd0);
        check_val("t6_cfg_incr", 32'(shift_ByteWrIncr), 32'd0);
        check_val("t6_cfg_step", 32'(shift_ByteWrStep), 32'd0);
        check_val("t6_din_en", 32'(shift_din_en), 32'd0);
        check_val("t6_done", 32'(req_done), 32'd0);
        check_val("t6_shift_rst_low", 32'(shift_Rst), 32'd0);
        check_val("t6_stall", 32'(cnt_stall), 32'd0);
        req_vld = 2'b11; #1;
        check_val("t6_rr_reset", 32'(req_rdy), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
